// File: rtl/hdc_msg_sequencer.sv
// hdc_msg_sequencer: streams one latched message to the encoder, triggers the classifier and returns its label
module hdc_msg_sequencer #(
  parameter int MSG_LEN = 160,
  parameter int CHAR_W  = 8,
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [MSG_LEN*CHAR_W-1:0] msg,
  input  logic [LEN_W-1:0]          length,
  output logic                      busy,
  output logic                      done,
  output logic [1:0]                result,
  output logic                      len_clamped,
  output logic                      enc_valid,
  input  logic                      enc_ready,
  output logic [CHAR_W-1:0]         enc_char,
  output logic [LEN_W-1:0]          enc_pos,
  output logic                      enc_first,
  output logic                      enc_last,
  output logic                      cls_start,
  input  logic                      cls_done,
  input  logic [1:0]                cls_label
`ifdef HDC_SEQ_TIMEOUT_EN
  , output logic                    cls_timeout
`endif
);
  localparam int MSG_W = MSG_LEN*CHAR_W;
  localparam logic [LEN_W-1:0] L_MAX = LEN_W'(MSG_LEN);
  typedef enum logic [2:0] {S_IDLE, S_FEED, S_CLS_REQ, S_CLS_WAIT, S_DONE} state_t;
  state_t             r_state;
  logic [MSG_W-1:0]   r_msg;
  logic [LEN_W-1:0]   r_last_pos;
  logic [LEN_W-1:0]   w_eff_len;
  logic [LEN_W-1:0]   w_pos_nx;
`ifdef HDC_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT+1);
  logic [CNT_W-1:0]   r_cnt;
`endif
  assign w_eff_len = (length > L_MAX) ? L_MAX : length;
  assign w_pos_nx  = enc_pos + LEN_W'(1);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_msg       <= '0;
      r_last_pos  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= 2'b11;
      len_clamped <= 1'b0;
      enc_valid   <= 1'b0;
      enc_char    <= '0;
      enc_pos     <= '0;
      enc_first   <= 1'b0;
      enc_last    <= 1'b0;
      cls_start   <= 1'b0;
`ifdef HDC_SEQ_TIMEOUT_EN
      r_cnt       <= '0;
      cls_timeout <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          len_clamped <= length > L_MAX;
          r_msg       <= msg << CHAR_W;
          r_last_pos  <= w_eff_len - LEN_W'(1);
`ifdef HDC_SEQ_TIMEOUT_EN
          cls_timeout <= 1'b0;
`endif
          if (w_eff_len == '0) begin
            r_state <= S_DONE;
            done    <= 1'b1;
            result  <= 2'b11;
          end else begin
            r_state   <= S_FEED;
            busy      <= 1'b1;
            enc_valid <= 1'b1;
            enc_char  <= msg[MSG_W-1 -: CHAR_W];
            enc_pos   <= '0;
            enc_first <= 1'b1;
            enc_last  <= w_eff_len == LEN_W'(1);
          end
        end
        S_FEED: if (enc_ready) begin
          if (enc_last) begin
            r_state   <= S_CLS_REQ;
            enc_valid <= 1'b0;
            enc_first <= 1'b0;
            enc_last  <= 1'b0;
            cls_start <= 1'b1;
          end else begin
            r_msg     <= r_msg << CHAR_W;
            enc_char  <= r_msg[MSG_W-1 -: CHAR_W];
            enc_pos   <= w_pos_nx;
            enc_first <= 1'b0;
            enc_last  <= w_pos_nx == r_last_pos;
          end
        end
        S_CLS_REQ: begin
          cls_start <= 1'b0;
          r_state   <= S_CLS_WAIT;
`ifdef HDC_SEQ_TIMEOUT_EN
          r_cnt     <= '0;
`endif
        end
        S_CLS_WAIT: if (cls_done) begin
          result  <= cls_label;
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_DONE;
        end
`ifdef HDC_SEQ_TIMEOUT_EN
        else if (r_cnt == CNT_W'(TIMEOUT-1)) begin
          result      <= 2'b11;
          cls_timeout <= 1'b1;
          done        <= 1'b1;
          busy        <= 1'b0;
          r_state     <= S_DONE;
        end else r_cnt <= r_cnt + CNT_W'(1);
`endif
        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hdc_msg_sequencer.sv
// tb_hdc_msg_sequencer: directed bench for hdc_msg_sequencer
module tb_hdc_msg_sequencer;
  localparam int MSG_LEN = 160;
  localparam int CHAR_W  = 8;
  localparam int LEN_W   = 8;
  logic                      clk = 1'b0;
  logic                      reset = 1'b1;
  logic                      start = 1'b0;
  logic [MSG_LEN*CHAR_W-1:0] msg = '0;
  logic [LEN_W-1:0]          length = '0;
  logic                      busy, done, len_clamped, enc_valid, enc_first, enc_last, cls_start;
  logic [1:0]                result;
  logic                      enc_ready = 1'b1;
  logic [CHAR_W-1:0]         enc_char;
  logic [LEN_W-1:0]          enc_pos;
  logic                      cls_done = 1'b0;
  logic [1:0]                cls_label = 2'b00;
`ifdef HDC_SEQ_TIMEOUT_EN
  logic                      cls_timeout;
`endif
  int n_cmp = 0, n_err = 0;
  int n_valid = 0, n_cls = 0, n_done = 0, n_unstable = 0;
  int cls_pend = 0;
  bit bp = 1'b0, cls_auto = 1'b1;
  logic [17:0] beats[$];
  logic        p_hold = 1'b0;
  logic [18:0] p_snap = '0;
  hdc_msg_sequencer #(.MSG_LEN(MSG_LEN), .CHAR_W(CHAR_W), .LEN_W(LEN_W), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .start(start), .msg(msg), .length(length),
    .busy(busy), .done(done), .result(result), .len_clamped(len_clamped),
    .enc_valid(enc_valid), .enc_ready(enc_ready), .enc_char(enc_char), .enc_pos(enc_pos),
    .enc_first(enc_first), .enc_last(enc_last), .cls_start(cls_start),
    .cls_done(cls_done), .cls_label(cls_label)
`ifdef HDC_SEQ_TIMEOUT_EN
    , .cls_timeout(cls_timeout)
`endif
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (enc_valid && enc_ready) beats.push_back({enc_char, enc_pos, enc_first, enc_last});
    if (enc_valid) n_valid++;
    if (cls_start) n_cls++;
    if (done) n_done++;
    if (p_hold && {enc_valid, enc_char, enc_pos, enc_first, enc_last} !== p_snap) n_unstable++;
    p_hold = enc_valid && !enc_ready && !reset;
    p_snap = {enc_valid, enc_char, enc_pos, enc_first, enc_last};
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    enc_ready = bp ? ~enc_ready : 1'b1;
    cls_done = 1'b0;
    if (cls_pend > 0) begin
      cls_pend--;
      if (cls_pend == 0) cls_done = 1'b1;
    end
    if (cls_start && cls_auto) cls_pend = 2;
  endtask
  task automatic go(input logic [LEN_W-1:0] len);
    length = len;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask
  task automatic wait_done(input int max);
    for (int k = 0; k < max && !done; k++) step();
    chk("done_seen", done, 1);
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_result"}, result, 2'b11);
    chk({tag, "_clamp"}, len_clamped, 0);
    chk({tag, "_valid"}, enc_valid, 0);
    chk({tag, "_char"}, enc_char, 0);
    chk({tag, "_pos"}, enc_pos, 0);
    chk({tag, "_first_last"}, {enc_first, enc_last}, 0);
    chk({tag, "_cls_start"}, cls_start, 0);
`ifdef HDC_SEQ_TIMEOUT_EN
    chk({tag, "_timeout"}, cls_timeout, 0);
`endif
  endtask
  initial begin
    int b0, d0, v0, c0, nl;
    step();
    step();
    reset = 1'b0;
    step();
    chk_reset_vals("rst");
    msg = '0;
    msg[(MSG_LEN-1)*8 +: 8] = 8'h68;
    msg[(MSG_LEN-2)*8 +: 8] = 8'h69;
    cls_label = 2'b01;
    b0 = beats.size();
    go(8'd2);
    chk("hi_beat0", {busy, enc_valid, enc_char, enc_pos, enc_first, enc_last}, {2'b11, 8'h68, 8'd0, 2'b10});
    step();
    chk("hi_beat1", {enc_valid, enc_char, enc_pos, enc_first, enc_last}, {1'b1, 8'h69, 8'd1, 2'b01});
    step();
    chk("hi_cls_start", {cls_start, enc_valid, busy}, 3'b101);
    step();
    chk("hi_cls_pulse", cls_start, 0);
    step();
    step();
    chk("hi_done", {done, busy, result}, {2'b10, 2'b01});
    step();
    chk("hi_after", {done, busy}, 0);
    chk("hi_nbeats", beats.size() - b0, 2);
    msg[(MSG_LEN-1)*8 +: 8] = 8'h61;
    msg[(MSG_LEN-2)*8 +: 8] = 8'h62;
    msg[(MSG_LEN-3)*8 +: 8] = 8'h63;
    cls_label = 2'b10;
    bp = 1'b1;
    enc_ready = 1'b1;
    b0 = beats.size();
    c0 = n_cls;
    go(8'd3);
    wait_done(40);
    bp = 1'b0;
    chk("bp_result", result, 2'b10);
    chk("bp_nbeats", beats.size() - b0, 3);
    chk("bp_beat0", beats[b0], {8'h61, 8'd0, 2'b10});
    chk("bp_beat1", beats[b0+1], {8'h62, 8'd1, 2'b00});
    chk("bp_beat2", beats[b0+2], {8'h63, 8'd2, 2'b01});
    chk("bp_stable", n_unstable, 0);
    chk("bp_ncls", n_cls - c0, 1);
    step();
    v0 = n_valid;
    c0 = n_cls;
    go(8'd0);
    chk("zero_done", {done, busy, result}, {2'b10, 2'b11});
    step();
    chk("zero_after", done, 0);
    chk("zero_no_valid", n_valid - v0, 0);
    chk("zero_no_cls", n_cls - c0, 0);
    for (int i = 0; i < MSG_LEN; i++) msg[(MSG_LEN-1-i)*8 +: 8] = 8'(i*7+3);
    cls_label = 2'b00;
    b0 = beats.size();
    go(8'd200);
    chk("clamp_flag", len_clamped, 1);
    wait_done(400);
    chk("clamp_result", result, 2'b00);
    chk("clamp_nbeats", beats.size() - b0, 160);
    chk("clamp_first", beats[b0], {8'd3, 8'd0, 2'b10});
    chk("clamp_last", beats[b0+159], {8'h5C, 8'd159, 2'b01});
    nl = 0;
    for (int i = b0; i < beats.size(); i++) nl += int'(beats[i][0]);
    chk("clamp_nlast", nl, 1);
    step();
    chk("clamp_hold", len_clamped, 1);
    d0 = n_done;
    go(8'd10);
    chk("rms_clamp_clr", len_clamped, 0);
    for (int i = 0; i < 5; i++) step();
    chk("rms_pos5", {enc_valid, enc_pos}, {1'b1, 8'd5});
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_reset_vals("rms");
    for (int i = 0; i < 6; i++) step();
    chk("rms_no_done", n_done - d0, 0);
    cls_label = 2'b01;
    go(8'd2);
    wait_done(20);
    chk("rms_fresh_result", result, 2'b01);
    step();
    d0 = n_done;
    b0 = beats.size();
    cls_label = 2'b10;
    go(8'd4);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(30);
    for (int i = 0; i < 5; i++) step();
    chk("sb_ndone", n_done - d0, 1);
    chk("sb_nbeats", beats.size() - b0, 4);
    chk("sb_idle", {busy, enc_valid}, 0);
`ifdef HDC_SEQ_TIMEOUT_EN
    cls_auto = 1'b0;
    go(8'd1);
    step();
    chk("to_cls_start", cls_start, 1);
    for (int i = 0; i < 16; i++) step();
    chk("to_not_yet", done, 0);
    step();
    chk("to_fire", {done, result, cls_timeout}, {1'b1, 2'b11, 1'b1});
    step();
    chk("to_hold", cls_timeout, 1);
    go(8'd1);
    chk("to_clear", cls_timeout, 0);
    step();
    for (int i = 0; i < 16; i++) step();
    cls_done = 1'b1;
    cls_label = 2'b01;
    step();
    chk("to_race", {done, result, cls_timeout}, {1'b1, 2'b01, 1'b0});
    cls_auto = 1'b1;
    step();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/hdc_msg_sequencer.md
Name: hdc_msg_sequencer

Overview:
- Control block that sequences one message through the HDC classification datapath.
- Latches a packed character message and its length, then streams characters with positions to the item/position encoder over a valid/ready handshake.
- After the last character it triggers the similarity classifier and returns the HAM/SPAM label with a done pulse.
- Sits between the top-level message interface and the encoder/classifier pair inside main.

Parameters:
MSG_LEN, 160, maximum characters per message
CHAR_W, 8, bits per character
LEN_W, 8, width of length input and position counter
TIMEOUT, 1024, classifier watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
start  in  1  request to process msg/length; sampled only in IDLE
msg  in  MSG_LEN*CHAR_W  packed message; char 0 in the most-significant byte, i.e. char i = msg[(MSG_LEN-1-i)*CHAR_W +: CHAR_W]
length  in  LEN_W  number of valid characters
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle completion pulse
result  out  2  label; 2'b11 = inconclusive
len_clamped  out  1  length exceeded MSG_LEN for the current or last message
enc_valid  out  1  character beat valid
enc_ready  in  1  encoder accepts beat
enc_char  out  CHAR_W  current character
enc_pos  out  LEN_W  current character index
enc_first  out  1  beat is index 0
enc_last  out  1  beat is final index
cls_start  out  1  one-cycle classifier trigger
cls_done  in  1  classifier finished
cls_label  in  2  classifier label, valid with cls_done
cls_timeout  out  1  watchdog fired (exists only with the optional feature)

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous, active-high, named reset.
- Reset values: state IDLE; busy=0, done=0, result=2'b11, len_clamped=0, enc_valid=0, enc_char=0, enc_pos=0, enc_first=0, enc_last=0, cls_start=0, cls_timeout=0.
- States: IDLE, FEED, CLS_REQ, CLS_WAIT, DONE.
- IDLE:
  - On start=1, latch msg and the effective length eff_len = min(length, MSG_LEN).
  - Set len_clamped = (length > MSG_LEN).
  - eff_len==0: go to DONE with result=2'b11; no encoder or classifier activity.
  - Otherwise go to FEED with pos=0.
- FEED:
  - enc_valid=1; enc_char = latched char[pos]; enc_pos=pos; enc_first=(pos==0); enc_last=(pos==eff_len-1).
  - A beat transfers when enc_valid && enc_ready.
  - While enc_valid=1 and enc_ready=0, all enc_* outputs hold stable.
  - On transfer with enc_last=1, go to CLS_REQ; otherwise pos increments by 1.
- CLS_REQ: cls_start=1 for exactly one cycle, enc_valid=0, then go to CLS_WAIT.
- CLS_WAIT:
  - On cls_done=1, register cls_label into result and go to DONE.
  - cls_done outside CLS_WAIT is ignored.
- DONE: done=1 for one cycle, busy=0 in that cycle, then go to IDLE.
- result holds until the next completion. len_clamped holds until the next accepted start.
- busy=1 in FEED, CLS_REQ and CLS_WAIT; start is ignored while busy or in DONE.
- Latency with enc_ready tied high:
  - first enc_valid in the cycle after start;
  - L transfers in L consecutive cycles;
  - cls_start in the cycle after the last transfer;
  - done in the cycle after cls_done.
- reset mid-operation: immediate return to IDLE with reset values. The in-flight beat is abandoned and no done is issued.
- pos counter width LEN_W; eff_len ≤ MSG_LEN guarantees no wrap.

Optional Feature:
HDC_SEQ_TIMEOUT_EN
- Defined:
  - A cycle counter runs in CLS_WAIT.
  - If TIMEOUT cycles elapse without cls_done, go to DONE with result=2'b11 and cls_timeout=1.
  - cls_timeout holds until the next accepted start, which clears it.
  - cls_done arriving in the same cycle the count reaches TIMEOUT wins: the label is taken and cls_timeout stays 0.
- Undefined: no counter and no cls_timeout port; CLS_WAIT waits indefinitely.

Test Plan:
- Basic message: msg="hi" (char0=8'h68, char1=8'h69), length=2, enc_ready=1, cls_done with cls_label=2'b01 two cycles after cls_start.
  -> beats (68,0,first) then (69,1,last); single cls_start; done pulse; result=01; busy then low.
- Backpressure: length=3, enc_ready toggling 0/1 per cycle.
  -> each beat held stable while ready=0; exactly 3 transfers at pos 0,1,2; enc_last only on pos 2.
- Zero length: length=0, start.
  -> done within 2 cycles, result=11, enc_valid and cls_start never asserted.
- Clamp: length=200 with MSG_LEN=160.
  -> len_clamped=1; exactly 160 beats; last beat enc_pos=159 with enc_last=1.
- Reset mid-stream: assert reset during beat pos 5 of a length-10 message.
  -> next cycle all outputs at reset values, no done; a fresh start then completes normally.
- Start while busy: second start pulse during FEED.
  -> ignored; only one done pulse.
- Timeout, with HDC_SEQ_TIMEOUT_EN defined and TIMEOUT=16: cls_done never asserted.
  -> done 16 cycles into CLS_WAIT with result=11 and cls_timeout=1.
